mips_instr_encoder: RTL and testbench

Instruction encoder and loader: the inverse of the main control unit's opcode decode. It accepts instruction requests by class (R-format, LW, SW, BEQ, J) plus operand fields, and assembles standard 32-bit MIPS words using the same opcodes the decoder recognises. Words are buffered in a small FIFO and streamed, with sequential word-aligned addresses, into instruction memory over a valid/ready write port. It sits in front of instruction memory for bench program loading and self-test.

---
 rtl/mips_instr_encoder.sv | 136 +++++++++++++
 tb/tb_mips_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Assembles 32-bit MIPS instruction words from a class code plus operand
//   fields. It buffers the words in a small FIFO and streams them into
//   instruction memory at sequential word-aligned byte addresses.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   BASE_ADDR  byte address of the first emitted word (word-aligned)
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   request handshake
//   cmd_class             0=R 1=LW 2=SW 3=BEQ 4=J, 5-7 illegal
//   cmd_rs/rt/rd/shamt    register and shift fields
//   cmd_funct             R-format function field
//   cmd_imm               LW/SW offset or BEQ displacement
//   cmd_target            J word target
//   out_valid/out_ready   memory write handshake
//   out_addr, out_instr   byte address and word being written
//   illegal               one-cycle pulse after an illegal class is consumed
//   emitted               completed output handshakes (wraps at 16 bits)
module mips_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_class,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_shamt,
  input  logic [5:0]  cmd_funct,
  input  logic [15:0] cmd_imm,
  input  logic [25:0] cmd_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic        illegal,
  output logic [15:0] emitted
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   emitted_q, emitted_d;
  logic          illegal_q, illegal_d;

  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (cmd_class)
      3'd0:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
      3'd1:    enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
      3'd2:    enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
      3'd3:    enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
      3'd4:    enc_word = {6'b000010, cmd_target};
      default: legal    = 1'b0;
    endcase
  end

  // No bypass when full: a pop this cycle only frees a slot for the next one.
  assign cmd_ready = !reset && (occ_q < FULL_OCC);
  assign out_valid = (occ_q != '0);
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign emitted   = emitted_q;
  assign illegal   = illegal_q;

  assign accept = cmd_valid && cmd_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    addr_d    = addr_q;
    emitted_d = emitted_q;
    illegal_d = accept && !legal;

    if (push) begin
      mem_d[wr_ptr_q] = enc_word;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      addr_d    = addr_q + 32'd4;
      emitted_d = emitted_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      addr_q    <= BASE_ADDR;
      emitted_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      addr_q    <= addr_d;
      emitted_q <= emitted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_class = '0;
  logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
  logic [5:0]  cmd_funct = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic        out_ready = 1'b0;

  logic        rdy_a, ov_a, ill_a, rdy_b, ov_b, ill_b;
  logic [31:0] addr_a, instr_a, addr_b, instr_b;
  logic [15:0] em_a, em_b;

  wire cv_a  = cmd_valid && !sel;
  wire cv_b  = cmd_valid && sel;
  wire or_a  = out_ready && !sel;
  wire or_b  = out_ready && sel;

  wire        s_ready = sel ? rdy_b   : rdy_a;
  wire        s_valid = sel ? ov_b    : ov_a;
  wire [31:0] s_addr  = sel ? addr_b  : addr_a;
  wire [31:0] s_instr = sel ? instr_b : instr_a;
  wire        s_ill   = sel ? ill_b   : ill_a;
  wire [15:0] s_em    = sel ? em_b    : em_a;

  mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cv_a), .cmd_ready(rdy_a),
    .cmd_class(cmd_class), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .out_valid(ov_a), .out_ready(or_a),
    .out_addr(addr_a), .out_instr(instr_a), .illegal(ill_a), .emitted(em_a));

  mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cv_b), .cmd_ready(rdy_b),
    .cmd_class(cmd_class), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_funct(cmd_funct), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .out_valid(ov_b), .out_ready(or_b),
    .out_addr(addr_b), .out_instr(instr_b), .illegal(ill_b), .emitted(em_b));

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ill_cnt = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [63:0] exp_q[$];
  int          accept_cyc = 0;
  int          pop_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && s_ill) ill_cnt++;
    if (!reset && s_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %08h at %08h, none expected", s_instr, s_addr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_addr", s_addr, e[63:32]);
        chk("out_instr", s_instr, e[31:0]);
      end
    end
  end

  task automatic do_reset(input logic which);
    @(posedge clk); #1;
    sel = which; reset = 1'b1; cmd_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    exp_addr = which ? 32'hFFFF_FFF8 : 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    ill_cnt = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] w);
    int n;
    cmd_valid = 1'b1; cmd_class = cls; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_shamt = sh; cmd_funct = fn; cmd_imm = imm; cmd_target = tgt;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: cmd_ready stayed %0b, required 1", s_ready);
        break;
      end
    end
    if (s_ready) begin
      accept_cyc = cyc;
      if (cls <= 3'd4) begin
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 32'd4;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                         input logic [31:0] w);
    send(3'd1, rs, rt, 5'd0, 5'd0, 6'd0, imm, 26'd0, w);
  endtask

  task automatic send_j(input logic [25:0] tgt, input logic [31:0] w);
    send(3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, tgt, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("ready_in_reset", {31'd0, rdy_a}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_out_instr", instr_a, 32'h0);
    chk("rst_out_addr", addr_a, 32'h0);
    chk("rst_illegal", {31'd0, ill_a}, 32'd0);
    chk("rst_emitted", {16'd0, em_a}, 32'd0);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);

    // Basic encode
    do_reset(1'b0);
    out_ready = 1'b1;
    send(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h00221820);
    send_lw(5'd4, 5'd5, 16'h0008, 32'h8C850008);
    send(3'd2, 5'd4, 5'd6, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'h0, 32'hAC86FFFC);
    send(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'h0, 32'h10220003);
    send_j(26'h0000100, 32'h08000100);
    drain();
    chk("basic_emitted", {16'd0, s_em}, 32'd5);
    chk("basic_next_addr", s_addr, 32'h14);

    // Backpressure and full
    do_reset(1'b0);
    send_lw(5'd1, 5'd1, 16'h0001, 32'h8C210001);
    send_lw(5'd2, 5'd2, 16'h0002, 32'h8C420002);
    send_lw(5'd3, 5'd3, 16'h0003, 32'h8C630003);
    send_lw(5'd4, 5'd4, 16'h0004, 32'h8C840004);
    fork
      send_lw(5'd5, 5'd5, 16'h0005, 32'h8CA50005);
      begin
        @(negedge clk);
        chk("full_ready_low", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_addr", s_addr, 32'h0);
          chk("stall_instr", s_instr, 32'h8C210001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        pop_cyc = cyc;
      end
    join
    chk("fifth_accept_cycle", accept_cyc, pop_cyc + 1);
    drain();
    chk("bp_emitted", {16'd0, s_em}, 32'd5);

    // Illegal class between two LWs
    do_reset(1'b0);
    out_ready = 1'b1;
    send_lw(5'd1, 5'd2, 16'h0010, 32'h8C220010);
    send(3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0);
    send_lw(5'd3, 5'd4, 16'h0020, 32'h8C640020);
    drain();
    chk("illegal_pulses", ill_cnt, 1);
    chk("illegal_emitted", {16'd0, s_em}, 32'd2);

    // Simultaneous push/pop at occupancy 2
    do_reset(1'b0);
    send_j(26'h0000001, 32'h08000001);
    send_j(26'h0000002, 32'h08000002);
    out_ready = 1'b1;
    fork
      begin
        send_j(26'h0000003, 32'h08000003);
        send_j(26'h0000004, 32'h08000004);
        send_j(26'h0000005, 32'h08000005);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("occ_steady", {29'd0, dut_a.occ_q}, 32'd2);
        end
      end
    join
    drain();
    chk("pp_emitted", {16'd0, s_em}, 32'd5);

    // Reset mid-operation during a handshake
    do_reset(1'b0);
    send_j(26'h0000011, 32'h08000011);
    send_j(26'h0000012, 32'h08000012);
    send_j(26'h0000013, 32'h08000013);
    reset = 1'b1; out_ready = 1'b1;
    exp_q.delete();
    exp_addr = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, s_valid}, 32'd0);
    chk("mid_rst_addr", s_addr, 32'h0);
    chk("mid_rst_emitted", {16'd0, s_em}, 32'd0);
    @(posedge clk); #1;
    send_j(26'h0000021, 32'h08000021);
    drain();
    chk("mid_rst_after", {16'd0, s_em}, 32'd1);

    // Address and emitted-count wrap
    do_reset(1'b1);
    out_ready = 1'b1;
    chk("wrap_base", s_addr, 32'hFFFF_FFF8);
    send_j(26'h0000100, 32'h08000100);
    send_j(26'h0000200, 32'h08000200);
    send_j(26'h0000300, 32'h08000300);
    drain();
    chk("wrap_addr_after3", s_addr, 32'h0000_0004);
    for (int i = 0; i < 65532; i++) send_j(26'h0000100, 32'h08000100);
    drain();
    chk("emitted_ffff", {16'd0, s_em}, 32'h0000FFFF);
    send_j(26'h0000100, 32'h08000100);
    drain();
    chk("emitted_wrap", {16'd0, s_em}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
